alu_sched: RTL and testbench

Two-port round-robin scheduler that shares one combinational ALU_STRUCTURAL instance between two requesters, e.g. the execute stage and the branch-compare unit. It accepts one operation at a time over a valid/ready handshake and registers the operands driving the ALU. After a fixed settle time it captures RES/CY and returns them to the granted requester over a valid/ready response channel.

---
 rtl/alu_sched_pkg.sv | 13 +
 rtl/rr_arb2.sv | 17 +
 rtl/alu_sched.sv | 121 ++++++++++++
 tb/tb_alu_sched.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and widths for the two-port ALU scheduler.
package alu_sched_pkg;

  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the port not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = ~last;
    end else if (req == 2'b10) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one combinational ALU between two requesters; one op in flight,
// operands held on the ALU for ALU_LAT cycles before the result is captured.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*W-1:0]        req_a,
  input  logic [2*W-1:0]        req_b,
  input  logic [1:0]            req_diff,
  input  logic [2*ALU_OP_W-1:0] req_op,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [W-1:0]          rsp_res,
  output logic                  rsp_cy,
  output logic [W-1:0]          alu_a,
  output logic [W-1:0]          alu_b,
  output logic                  alu_diff,
  output logic [ALU_OP_W-1:0]   alu_op,
  input  logic [W-1:0]          alu_res,
  input  logic                  alu_cy,
  output logic                  busy
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last_grant;
  logic             grant;
  logic             load;
  logic             capture;
  logic             rsp_clear;

  rr_arb2 u_arb (
    .req   (req_valid),
    .last  (last_grant),
    .grant (grant)
  );

  // State, settle counter and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Next state; req_ready follows valid so it never gates the requester's valid
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 2'b00;
    load      = 1'b0;
    capture   = 1'b0;
    rsp_clear = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready[grant] = req_valid[grant];
        if (req_valid[grant]) begin
          load      = 1'b1;
          cnt_nxt   = CNT_W'(ALU_LAT - 1);
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_valid[last_grant] && rsp_ready[last_grant]) begin
          rsp_clear = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers driving the ALU and the response holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_diff   <= 1'b0;
      alu_op     <= '0;
      rsp_res    <= '0;
      rsp_cy     <= 1'b0;
      rsp_valid  <= 2'b00;
    end else begin
      if (load) begin
        last_grant <= grant;
        alu_a      <= grant ? req_a[2*W-1:W] : req_a[W-1:0];
        alu_b      <= grant ? req_b[2*W-1:W] : req_b[W-1:0];
        alu_diff   <= req_diff[grant];
        alu_op     <= grant ? req_op[2*ALU_OP_W-1:ALU_OP_W] : req_op[ALU_OP_W-1:0];
      end
      if (capture) begin
        rsp_res   <= alu_res;
        rsp_cy    <= alu_cy;
        rsp_valid <= last_grant ? 2'b10 : 2'b01;
      end else if (rsp_clear) begin
        rsp_valid <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: one instance with ALU_LAT=1 and one with ALU_LAT=3,
// each driving a small add/subtract ALU model.
module tb_alu_sched;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst1_n, rst3_n;
  logic [1:0]    req_valid;
  logic [2*W-1:0] req_a, req_b;
  logic [1:0]    req_diff;
  logic [5:0]    req_op;
  logic [1:0]    rsp_ready;

  logic [1:0]    req_ready1, rsp_valid1, req_ready3, rsp_valid3;
  logic [W-1:0]  rsp_res1, alu_a1, alu_b1, alu_res1, rsp_res3, alu_a3, alu_b3, alu_res3;
  logic          rsp_cy1, alu_diff1, alu_cy1, busy1, rsp_cy3, alu_diff3, alu_cy3, busy3;
  logic [2:0]    alu_op1, alu_op3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ALU model: OP=0 adds, DIFF=1 turns it into A + ~B + 1
  assign {alu_cy1, alu_res1} = alu_diff1 ? ({1'b0, alu_a1} + {1'b0, ~alu_b1} + 33'd1)
                                         : ({1'b0, alu_a1} + {1'b0, alu_b1});
  assign {alu_cy3, alu_res3} = alu_diff3 ? ({1'b0, alu_a3} + {1'b0, ~alu_b3} + 33'd1)
                                         : ({1'b0, alu_a3} + {1'b0, alu_b3});

  alu_sched #(.W(W), .ALU_LAT(1)) u1 (
    .clk(clk), .rst_n(rst1_n), .req_valid(req_valid), .req_ready(req_ready1),
    .req_a(req_a), .req_b(req_b), .req_diff(req_diff), .req_op(req_op),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_res(rsp_res1), .rsp_cy(rsp_cy1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_diff(alu_diff1), .alu_op(alu_op1),
    .alu_res(alu_res1), .alu_cy(alu_cy1), .busy(busy1)
  );

  alu_sched #(.W(W), .ALU_LAT(3)) u3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(req_valid), .req_ready(req_ready3),
    .req_a(req_a), .req_b(req_b), .req_diff(req_diff), .req_op(req_op),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_res(rsp_res3), .rsp_cy(rsp_cy3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_diff(alu_diff3), .alu_op(alu_op3),
    .alu_res(alu_res3), .alu_cy(alu_cy3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst1_n = 1'b0; rst3_n = 1'b0;
    req_valid = 2'b00; req_a = '0; req_b = '0; req_diff = 2'b00; req_op = '0;
    rsp_ready = 2'b00;
    tick(); tick();

    // Reset state
    chk("rst_rsp_valid", rsp_valid1, 2'b00);
    chk("rst_busy", busy1, 0);
    chk("rst_alu_a", alu_a1, 0);
    chk("rst_rsp_res", rsp_res1, 0);
    rst1_n = 1'b1;
    tick();

    // 1. Single op on port 0: 5 + 3
    req_valid = 2'b01; req_a[31:0] = 32'd5; req_b[31:0] = 32'd3;
    #1 chk("t1_req_ready", req_ready1, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("t1_exec_busy", busy1, 1);
    chk("t1_exec_alu_a", alu_a1, 32'd5);
    chk("t1_exec_rsp_valid", rsp_valid1, 2'b00);
    tick();
    chk("t1_rsp_valid", rsp_valid1, 2'b01);
    chk("t1_rsp_res", rsp_res1, 32'd8);
    chk("t1_rsp_cy", rsp_cy1, 0);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    chk("t1_done_valid", rsp_valid1, 2'b00);
    chk("t1_done_busy", busy1, 0);

    // 2. Simultaneous requests right after reset
    rst1_n = 1'b0;
    #2 rst1_n = 1'b1;
    req_valid = 2'b11;
    req_a = {32'hFFFF_FFFF, 32'd1}; req_b = {32'd1, 32'd2};
    #1 chk("t2_first_grant", req_ready1, 2'b01);
    tick();
    req_valid = 2'b10;
    chk("t2_exec_no_accept", req_ready1, 2'b00);
    tick();
    chk("t2_p0_valid", rsp_valid1, 2'b01);
    chk("t2_p0_res", rsp_res1, 32'd3);
    rsp_ready = 2'b11;
    tick();
    rsp_ready = 2'b00;
    chk("t2_second_grant", req_ready1, 2'b10);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t2_p1_valid", rsp_valid1, 2'b10);
    chk("t2_p1_res", rsp_res1, 32'd0);
    chk("t2_p1_cy", rsp_cy1, 1);

    // 3. Backpressure: port 1 withholds ready, new operands wait on the inputs
    req_valid = 2'b11;
    req_a = {32'd200, 32'd100}; req_b = {32'd2, 32'd1};
    rsp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_rsp_valid", rsp_valid1, 2'b10);
      chk("t3_rsp_res", rsp_res1, 32'd0);
      chk("t3_alu_a", alu_a1, 32'hFFFF_FFFF);
      chk("t3_alu_b", alu_b1, 32'd1);
      chk("t3_req_ready", req_ready1, 2'b00);
      chk("t3_busy", busy1, 1);
    end
    rsp_ready = 2'b10;
    tick();

    // 5. Fairness with both ports always valid and ready tied high
    rsp_ready = 2'b11;
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  g_exp;
      logic [31:0] r_exp;
      g_exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      r_exp = (i % 2 == 0) ? 32'd101 : 32'd202;
      chk("t5_grant", req_ready1, g_exp);
      tick();
      tick();
      chk("t5_rsp_port", rsp_valid1, g_exp);
      chk("t5_rsp_res", rsp_res1, r_exp);
      tick();
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
    tick();

    // 4. ALU_LAT=3: port 1 computes 10 - 3
    rst1_n = 1'b0; rst3_n = 1'b1;
    req_valid = 2'b10; req_a = {32'd10, 32'd0}; req_b = {32'd3, 32'd0};
    req_diff = 2'b10;
    #1 chk("t4_req_ready", req_ready3, 2'b10);
    tick();
    req_valid = 2'b00; req_diff = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      chk("t4_early_valid", rsp_valid3, 2'b00);
      tick();
    end
    chk("t4_rsp_valid", rsp_valid3, 2'b10);
    chk("t4_rsp_res", rsp_res3, 32'd7);
    chk("t4_rsp_cy", rsp_cy3, 1);
    chk("t4_alu_diff", alu_diff3, 1);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    chk("t4_done_busy", busy3, 0);

    // 6. Reset while an op is in EXEC
    req_valid = 2'b01; req_a = {32'd2, 32'd1}; req_b = {32'd2, 32'd1}; req_op = 6'b000_101;
    #1 chk("t6_req_ready", req_ready3, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t6_exec_busy", busy3, 1);
    chk("t6_exec_op", alu_op3, 3'd5);
    rst3_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy3, 0);
    chk("t6_rst_alu_a", alu_a3, 0);
    chk("t6_rst_alu_op", alu_op3, 0);
    chk("t6_rst_rsp_res", rsp_res3, 0);
    chk("t6_rst_rsp_valid", rsp_valid3, 2'b00);
    #2 rst3_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_rsp", rsp_valid3, 2'b00);
    end
    req_valid = 2'b11;
    #1 chk("t6_tie_grant", req_ready3, 2'b01);
    req_valid = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
